// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: digit codes and enables in,
// active-low anode/segment drive and the frame marker out.
interface seg7_scan_driver_if;
    logic [31:0] digits_in;
    logic [7:0]  digit_en;
    logic [7:0]  AN;
    logic [6:0]  CAT;
    logic        frame_start;

    modport master (
        output digits_in,
        output digit_en,
        input  AN,
        input  CAT,
        input  frame_start
    );

    modport slave (
        input  digits_in,
        input  digit_en,
        output AN,
        output CAT,
        output frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// 8-digit common-anode 7-segment scan driver.
// One digit per slot of DIV = CLK_HZ/SLOT_HZ cycles; all anodes are held off
// for the first BLANK_CYCLES of every slot to suppress ghosting. Digit codes
// and enables are captured once per frame so mid-scan updates cannot tear.
// Optional macro SEG7_LZ_BLANK_EN: leading-zero blanking of digits 7..1.
module seg7_scan_driver #(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned SLOT_HZ      = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic               clk_in,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus
);

    localparam int unsigned DIV   = CLK_HZ / SLOT_HZ;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shadow_dig_q, shadow_dig_d;
    logic [7:0]       shadow_en_q, shadow_en_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       cat_q, cat_d;
    logic             fs_q, fs_d;
    logic             capture;
    logic [3:0]       cur_digit;
    logic             digit_on;
    logic [7:0]       lz_ok;

    // Active-low gfedcba segment pattern for a hex digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0:    seg_decode = 7'h40;
            4'h1:    seg_decode = 7'h79;
            4'h2:    seg_decode = 7'h24;
            4'h3:    seg_decode = 7'h30;
            4'h4:    seg_decode = 7'h19;
            4'h5:    seg_decode = 7'h12;
            4'h6:    seg_decode = 7'h02;
            4'h7:    seg_decode = 7'h78;
            4'h8:    seg_decode = 7'h00;
            4'h9:    seg_decode = 7'h10;
            4'hA:    seg_decode = 7'h08;
            4'hB:    seg_decode = 7'h03;
            4'hC:    seg_decode = 7'h46;
            4'hD:    seg_decode = 7'h21;
            4'hE:    seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

`ifdef SEG7_LZ_BLANK_EN
    // Digit i stays lit only if some digit at or above i is non-zero; digit 0 always lit.
    always_comb begin
        logic nz;
        nz       = 1'b0;
        lz_ok    = '0;
        lz_ok[0] = 1'b1;
        for (int unsigned i = 7; i >= 1; i--) begin
            nz       = nz | (shadow_dig_d[4*i +: 4] != 4'h0);
            lz_ok[i] = nz;
        end
    end
`else
    // No leading-zero rule: only the captured enables gate the anodes.
    always_comb begin
        lz_ok = '1;
    end
`endif

    // Slot/digit sequencing, frame capture and next output values.
    always_comb begin
        capture      = (cnt_q == '0) && (idx_q == '0);
        shadow_dig_d = capture ? bus.digits_in : shadow_dig_q;
        shadow_en_d  = capture ? bus.digit_en  : shadow_en_q;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end

        fs_d = capture;

        // Decode from the post-capture shadow so the frame's first output
        // cycle already reflects the freshly captured digits.
        cur_digit = shadow_dig_d[{idx_q, 2'b00} +: 4];
        cat_d     = seg_decode(cur_digit);
        digit_on  = shadow_en_d[idx_q] & lz_ok[idx_q];

        if ((cnt_q < CNT_BLANK) || !digit_on) begin
            an_d = '1;
        end else begin
            an_d = ~(8'h01 << idx_q);
        end
    end

    // State and registered display outputs; reset blanks the display immediately.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_dig_q <= '0;
            shadow_en_q  <= '0;
            an_q         <= '1;
            cat_q        <= '1;
            fs_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_en_q  <= shadow_en_d;
            an_q         <= an_d;
            cat_q        <= cat_d;
            fs_q         <= fs_d;
        end
    end

    assign bus.AN          = an_q;
    assign bus.CAT         = cat_q;
    assign bus.frame_start = fs_q;

endmodule
